// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

  // Widest operand abs_w handles; callers sign-extend into it and truncate back.
  localparam int unsigned ABS_W = 64;

  function automatic logic [ABS_W-1:0] abs_w(input logic [ABS_W-1:0] x);
    return x[ABS_W-1] ? (~x + ABS_W'(1)) : x;
  endfunction

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier, one partial product per clock, valid/ready on
// both sides. Signed operands are multiplied as magnitudes and the sign is reapplied.
module mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               signed_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  mul_state_t       state;
  mul_state_t       state_nx;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             neg;

  logic             accept_c;
  logic             last_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic             neg_c;
  logic [PW-1:0]    prod_nx_c;

  // Operand conditioning for the capture cycle.
  always_comb begin
    a_mag_c = a_i;
    b_mag_c = b_i;
    neg_c   = 1'b0;
    if (signed_i) begin
      a_mag_c = WIDTH'(abs_w(ABS_W'($signed(a_i))));
      b_mag_c = WIDTH'(abs_w(ABS_W'($signed(b_i))));
      neg_c   = a_i[WIDTH-1] ^ b_i[WIDTH-1];
    end
  end

  assign accept_c  = (state == IDLE) && valid_i;
  assign last_c    = (cnt == CNT_W'(WIDTH));
  assign prod_nx_c = neg ? (~acc + PW'(1)) : acc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_c) state_nx = BUSY;
      BUSY:    if (last_c)   state_nx = DONE;
      DONE:    if (ready_i)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      prod_o  <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
    end else begin
      ready_o <= (state_nx == IDLE);
      valid_o <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (accept_c) begin
            mcand  <= PW'(a_mag_c);
            mplier <= b_mag_c;
            neg    <= neg_c;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        BUSY: begin
          if (last_c) begin
            prod_o <= prod_nx_c;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corner cases, mid-operation reset and a
// randomized handshake stream checked against an arithmetic reference.
module tb_mul_seq;

  localparam int unsigned W      = 8;
  localparam int unsigned PW     = 2 * W;
  localparam int unsigned N_RAND = 1000;
  localparam int unsigned BUDGET = 60000;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          signed_i = 1'b0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [PW-1:0] prod_o;

  int n_cmp = 0;
  int n_err = 0;

  mul_seq #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .a_i      (a_i),
    .b_i      (b_i),
    .signed_i (signed_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .prod_o   (prod_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
    longint x;
    longint y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return PW'(x * y);
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return {1'b1, {(W-1){1'b0}}};
      2:       return '1;
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // One directed transaction: latency, result, optional backpressure, release.
  task automatic do_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [PW-1:0] exp, input int hold,
                        input logic early);
    int n;
    chk({tag, "/ready_before"}, 64'(ready_o), 64'(1));
    valid_i  = 1'b1;
    a_i      = a;
    b_i      = b;
    signed_i = s;
    ready_i  = early;
    tick();
    n = 0;
    while (valid_o !== 1'b1 && n < int'(4 * W)) begin
      a_i      = W'($urandom);
      b_i      = W'($urandom);
      signed_i = 1'($urandom);
      tick();
      n++;
    end
    valid_i = 1'b0;
    chk({tag, "/latency"}, 64'(n), 64'(W + 1));
    chk({tag, "/prod"}, 64'(prod_o), 64'(exp));
    repeat (hold) begin
      tick();
      chk({tag, "/hold"}, 64'({ready_o, valid_o, prod_o}), 64'({2'b01, exp}));
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk({tag, "/release"}, 64'({ready_o, valid_o, prod_o}), 64'({2'b10, exp}));
  endtask

  initial begin : main
    logic [PW-1:0] q[$];
    logic          va;
    logic          ri;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic          rs;
    logic          seen;
    int            n_acc;
    int            n_res;
    int            cyc;

    rst_i = 1'b1;
    tick();
    tick();
    chk("reset_state", 64'({ready_o, valid_o, prod_o}), 64'({2'b10, {PW{1'b0}}}));
    rst_i = 1'b0;
    tick();

    do_txn("u15x15", 8'd15, 8'd15, 1'b0, 16'h00E1, 0, 1'b0);
    do_txn("s_m7x6", 8'hF9, 8'h06, 1'b1, 16'hFFD6, 0, 1'b1);
    do_txn("s80x80", 8'h80, 8'h80, 1'b1, 16'h4000, 0, 1'b0);
    do_txn("u80x80", 8'h80, 8'h80, 1'b0, 16'h4000, 0, 1'b0);
    do_txn("uFFxFF", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, 1'b0);
    do_txn("sFFxFF", 8'hFF, 8'hFF, 1'b1, 16'h0001, 20, 1'b0);
    do_txn("s0xneg", 8'h00, 8'h85, 1'b1, 16'h0000, 0, 1'b0);
    do_txn("s7Fx80", 8'h7F, 8'h80, 1'b1, 16'hC080, 0, 1'b1);

    // Reset four edges after accept discards the operation.
    valid_i  = 1'b1;
    a_i      = 8'h37;
    b_i      = 8'h5B;
    signed_i = 1'b0;
    tick();
    valid_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("midreset_state", 64'({ready_o, valid_o, prod_o}), 64'({2'b10, {PW{1'b0}}}));
    seen = 1'b0;
    repeat (2 * W + 4) begin
      tick();
      if (valid_o !== 1'b0) seen = 1'b1;
    end
    chk("midreset_no_result", 64'(seen), 64'(0));

    // Random stream with random backpressure; handshakes are resolved at the next edge.
    n_acc = 0;
    n_res = 0;
    cyc   = 0;
    while ((n_acc < int'(N_RAND) || q.size() != 0) && cyc < int'(BUDGET)) begin
      va = (n_acc < int'(N_RAND)) && ($urandom_range(0, 3) != 0);
      ri = 1'($urandom);
      ra = rnd_op();
      rb = rnd_op();
      rs = 1'($urandom);
      valid_i  = va;
      ready_i  = ri;
      a_i      = ra;
      b_i      = rb;
      signed_i = rs;
      if (ready_o && va) begin
        q.push_back(ref_mul(ra, rb, rs));
        n_acc++;
      end
      if (valid_o && ri) begin
        if (q.size() == 0) begin
          chk("rand/unexpected_result", 64'(1), 64'(0));
        end else begin
          chk("rand/prod", 64'(prod_o), 64'(q.pop_front()));
          n_res++;
        end
      end
      tick();
      cyc++;
    end
    valid_i = 1'b0;
    ready_i = 1'b0;
    chk("rand/within_budget", 64'(cyc < int'(BUDGET)), 64'(1));
    chk("rand/result_count", 64'(n_res), 64'(N_RAND));
    chk("rand/queue_empty", 64'(q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Parametrised, iterative shift-add multiplier for WIDTH-bit operands with a 2*WIDTH-bit product.
- Supports unsigned and two's-complement signed operation, selected per transaction.
- Uses valid/ready handshakes on both input and output, so it drops into streaming datapaths.
- Trades throughput for area: one partial product per clock, so it replaces a wide combinational multiplier where timing or area is tight.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product width is 2*WIDTH.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  operands and mode are valid.
- ready_o  output  1  block can accept operands.
- a_i  input  WIDTH  multiplicand.
- b_i  input  WIDTH  multiplier.
- signed_i  input  1  1 = operands and product are two's complement; 0 = unsigned.
- valid_o  output  1  prod_o holds a completed result.
- ready_i  input  1  downstream accepts the result.
- prod_o  output  2*WIDTH  product.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state=IDLE, ready_o=1, valid_o=0, prod_o=0, internal counter/accumulator=0.
- Reset mid-operation: any in-flight or held result is discarded and no valid_o is issued for it.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i & ready_o, the block captures a_i, b_i and signed_i.
  - Operands are converted to magnitudes: if signed_i, |a| and |b| as unsigned WIDTH bits; otherwise raw values.
  - neg = signed_i & (a[MSB]^b[MSB]).
  - Accumulator and counter are cleared; next state is BUSY.
- BUSY:
  - ready_o=0.
  - Each cycle: if the current multiplier LSB is 1, add the shifted multiplicand into the 2*WIDTH-bit accumulator.
  - Shift the multiplicand left and the multiplier right; increment the counter.
  - After exactly WIDTH iterations, go to DONE.
  - prod_o is loaded with the accumulator, two's-complement negated if neg.
- DONE:
  - valid_o=1; prod_o is held stable.
  - On ready_i: valid_o drops and the state returns to IDLE.
  - ready_o=0 throughout DONE, so a new operand cannot be accepted in the same cycle the result is consumed.
- Latency and throughput:
  - valid_o rises exactly WIDTH+1 rising edges after the accepting edge.
  - Initiation interval is at least WIDTH+2 cycles.
- prod_o stability: prod_o keeps its last value outside DONE and changes only on the BUSY->DONE edge or on reset.
- Input changes: changes on a_i, b_i or signed_i while not accepting are ignored.
- Arithmetic corner cases:
  - Most-negative operand: magnitude 2^(WIDTH-1) fits unsigned WIDTH bits.
  - (-2^(W-1))*(-2^(W-1)) = 2^(2W-2), which fits signed 2*WIDTH. No overflow is possible in either mode.
  - Zero operand gives prod_o=0 regardless of sign (negating 0 yields 0).
- Backpressure: ready_i held low keeps DONE indefinitely with prod_o and valid_o stable.
- ready_i outside DONE has no effect.

Decomposition:
- Package mul_pkg:
  - typedef enum logic [1:0] mul_state_t {IDLE, BUSY, DONE}.
  - Function abs_w for two's-complement magnitude.
- Single module. No sub-module is needed: datapath and FSM together are about 150 lines.
- The counter width is $clog2(WIDTH+1), computed locally.

Test Plan:
- Unsigned, WIDTH=8, a=15, b=15, signed_i=0 -> prod_o=225 (0x00E1); valid_o rises 9 edges after the accept edge.
- Signed, a=0xF9 (-7), b=0x06 -> prod_o=0xFFD6 (-42). Also a=0x80, b=0x80 -> prod_o=0x4000 (16384).
- Same a=0x80, b=0x80 with signed_i=0 -> prod_o=0x4000. Then a=0xFF, b=0xFF unsigned -> 0xFE01; signed -> 0x0001.
- Backpressure: ready_i=0 for 20 cycles after valid_o -> prod_o and valid_o stable, ready_o=0. ready_i=1 -> valid_o=0 next edge, ready_o=1.
- Reset mid-BUSY (assert rst_i 4 cycles after accept) -> next edge ready_o=1, valid_o=0, prod_o=0; no result ever emitted for that transaction.
- Random back-to-back stream (1000 transactions, both modes, random ready_i) -> every prod_o matches the reference a*b. No lost or duplicated results. valid_i is ignored while ready_o=0.
